// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared definitions for the multi-channel fractional clock divider:
//   mode_e      - per-channel output mode (toggle clock or tick-only)
//   DEF_*       - default values for the divider parameters
// -----------------------------------------------------------------------------
package clk_div_pkg;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_TICK   = 1'b1
  } mode_e;

  localparam int DEF_NCH     = 4;
  localparam int DEF_CNT_W   = 16;
  localparam int DEF_FRAC_W  = 8;
  localparam int DEF_DEF_INT = 0;

endpackage

// File: rtl/clk_div_mc_if.sv
// -----------------------------------------------------------------------------
// clk_div_mc_if
// Control/status bundle of clk_div_mc. All vectors are NCH channels wide;
// channel i of div_int/div_frac occupies [i*W +: W].
//   en        master->slave  per-channel run enable
//   div_int   master->slave  integer divisors
//   div_frac  master->slave  fractional divisors
//   mode      master->slave  0 = toggle clock, 1 = tick-only
//   load      master->slave  capture request for div_int/div_frac/mode
//   load_ack  slave->master  1-cycle pulse when captured settings go live
//   clk_out   slave->master  divided clocks
//   tick      slave->master  1-cycle strobe per half-period event
// -----------------------------------------------------------------------------
interface clk_div_mc_if
  import clk_div_pkg::*;
#(
  parameter int NCH    = DEF_NCH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int FRAC_W = DEF_FRAC_W
) ();

  logic [NCH-1:0]        en;
  logic [NCH*CNT_W-1:0]  div_int;
  logic [NCH*FRAC_W-1:0] div_frac;
  logic [NCH-1:0]        mode;
  logic [NCH-1:0]        load;
  logic [NCH-1:0]        load_ack;
  logic [NCH-1:0]        clk_out;
  logic [NCH-1:0]        tick;

  modport master (
    output en, div_int, div_frac, mode, load,
    input  load_ack, clk_out, tick
  );

  modport slave (
    input  en, div_int, div_frac, mode, load,
    output load_ack, clk_out, tick
  );

endinterface

// File: rtl/clk_div_chan.sv
// -----------------------------------------------------------------------------
// clk_div_chan
// One fractional divider channel. A counter runs from 0 up to
// act_int + carry; reaching it is an "event": the counter restarts, the
// fractional accumulator adds act_frac and its carry stretches the next
// half-period by one cycle. New settings are staged in a shadow and only
// swapped in at an event (or immediately while disabled) so no runt
// half-period is produced.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   en                 run enable
//   div_int, div_frac  divisor to capture on load
//   mode               output mode to capture on load
//   load               capture request
//   load_ack           pulse when captured settings become active
//   clk_out            divided clock (held 1 in tick mode / when disabled)
//   tick               strobe the cycle after each event
// -----------------------------------------------------------------------------
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int FRAC_W  = DEF_FRAC_W,
  parameter int DEF_INT = DEF_DEF_INT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [CNT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              mode,
  input  logic              load,
  output logic              load_ack,
  output logic              clk_out,
  output logic              tick
);

  // One extra bit so act_int = all-ones plus a carry does not wrap.
  logic [CNT_W:0]    cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              carry_q, carry_d;
  logic              pend_q, pend_d;
  logic [CNT_W-1:0]  sh_int_q, sh_int_d;
  logic [FRAC_W-1:0] sh_frac_q, sh_frac_d;
  mode_e             sh_mode_q, sh_mode_d;
  logic [CNT_W-1:0]  act_int_q, act_int_d;
  logic [FRAC_W-1:0] act_frac_q, act_frac_d;
  mode_e             act_mode_q, act_mode_d;
  logic              tick_q, tick_d;
  logic              ack_q, ack_d;
  logic              clk_out_q, clk_out_d;

  logic [CNT_W:0]    limit_s;
  logic              evt_s;
  logic [FRAC_W:0]   acc_sum_s;
  mode_e             mode_eff_s;

  assign limit_s    = {1'b0, act_int_q} + {{CNT_W{1'b0}}, carry_q};
  assign evt_s      = (cnt_q == limit_s);
  assign acc_sum_s  = {1'b0, acc_q} + {1'b0, act_frac_q};
  // Mode that governs clk_out after this edge: a pending shadow goes live at
  // the event, so a switch to tick mode parks clk_out at 1 right away.
  assign mode_eff_s = pend_q ? sh_mode_q : act_mode_q;

  // Next-state logic for counter, accumulator, shadow/active settings, outputs.
  always_comb begin
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    carry_d    = carry_q;
    pend_d     = pend_q;
    sh_int_d   = sh_int_q;
    sh_frac_d  = sh_frac_q;
    sh_mode_d  = sh_mode_q;
    act_int_d  = act_int_q;
    act_frac_d = act_frac_q;
    act_mode_d = act_mode_q;
    tick_d     = 1'b0;
    ack_d      = 1'b0;
    clk_out_d  = clk_out_q;

    if (!en) begin
      // Idle: abandon any period, park outputs, apply a pending load now.
      cnt_d     = {(CNT_W+1){1'b0}};
      acc_d     = {FRAC_W{1'b0}};
      carry_d   = 1'b0;
      clk_out_d = 1'b1;
      if (pend_q) begin
        act_int_d  = sh_int_q;
        act_frac_d = sh_frac_q;
        act_mode_d = sh_mode_q;
        pend_d     = 1'b0;
        ack_d      = 1'b1;
      end else begin
        pend_d = pend_q;
      end
    end else if (evt_s) begin
      cnt_d              = {(CNT_W+1){1'b0}};
      {carry_d, acc_d}   = acc_sum_s;
      tick_d             = 1'b1;
      clk_out_d          = (mode_eff_s == MODE_TICK) ? 1'b1 : ~clk_out_q;
      if (pend_q) begin
        // Period just finished on old settings; start fresh on the new ones.
        act_int_d  = sh_int_q;
        act_frac_d = sh_frac_q;
        act_mode_d = sh_mode_q;
        pend_d     = 1'b0;
        acc_d      = {FRAC_W{1'b0}};
        carry_d    = 1'b0;
        ack_d      = 1'b1;
      end else begin
        pend_d = pend_q;
      end
    end else begin
      cnt_d = cnt_q + {{CNT_W{1'b0}}, 1'b1};
    end

    // A capture on the same edge as an apply stays pending for the next event.
    if (load) begin
      sh_int_d  = div_int;
      sh_frac_d = div_frac;
      sh_mode_d = mode_e'(mode);
      pend_d    = 1'b1;
    end else begin
      sh_int_d = sh_int_q;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= {(CNT_W+1){1'b0}};
      acc_q      <= {FRAC_W{1'b0}};
      carry_q    <= 1'b0;
      pend_q     <= 1'b0;
      sh_int_q   <= {CNT_W{1'b0}};
      sh_frac_q  <= {FRAC_W{1'b0}};
      sh_mode_q  <= MODE_TOGGLE;
      act_int_q  <= CNT_W'(DEF_INT);
      act_frac_q <= {FRAC_W{1'b0}};
      act_mode_q <= MODE_TOGGLE;
      tick_q     <= 1'b0;
      ack_q      <= 1'b0;
      clk_out_q  <= 1'b1;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      carry_q    <= carry_d;
      pend_q     <= pend_d;
      sh_int_q   <= sh_int_d;
      sh_frac_q  <= sh_frac_d;
      sh_mode_q  <= sh_mode_d;
      act_int_q  <= act_int_d;
      act_frac_q <= act_frac_d;
      act_mode_q <= act_mode_d;
      tick_q     <= tick_d;
      ack_q      <= ack_d;
      clk_out_q  <= clk_out_d;
    end
  end

  assign load_ack = ack_q;
  assign clk_out  = clk_out_q;
  assign tick     = tick_q;

endmodule

// File: rtl/clk_div_mc.sv
// -----------------------------------------------------------------------------
// clk_div_mc
// NCH independent fractional clock dividers. The top only slices the
// interface vectors and instantiates one clk_div_chan per channel.
// Ports:
//   clk    clock
//   reset  synchronous active-high reset
//   bus    clk_div_mc_if slave: en, div_int, div_frac, mode, load in;
//          load_ack, clk_out, tick out
// -----------------------------------------------------------------------------
module clk_div_mc
  import clk_div_pkg::*;
#(
  parameter int NCH     = DEF_NCH,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int FRAC_W  = DEF_FRAC_W,
  parameter int DEF_INT = DEF_DEF_INT
) (
  input  logic         clk,
  input  logic         reset,
  clk_div_mc_if.slave  bus
);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    clk_div_chan #(
      .CNT_W   (CNT_W),
      .FRAC_W  (FRAC_W),
      .DEF_INT (DEF_INT)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .en       (bus.en[i]),
      .div_int  (bus.div_int[i*CNT_W +: CNT_W]),
      .div_frac (bus.div_frac[i*FRAC_W +: FRAC_W]),
      .mode     (bus.mode[i]),
      .load     (bus.load[i]),
      .load_ack (bus.load_ack[i]),
      .clk_out  (bus.clk_out[i]),
      .tick     (bus.tick[i])
    );
  end

endmodule

// File: doc/clk_div_mc.md
CLK_DIV_MC -- requirements
Module: clk_div_mc

Interface
REQ-001 SHALL have parameter NCH, default 4: number of independent divider channels.
REQ-002 SHALL have parameter CNT_W, default 16: integer divisor width.
REQ-003 SHALL have parameter FRAC_W, default 8: fractional divisor width; 0 is not supported.
REQ-004 SHALL have parameter DEF_INT, default 0: integer divisor loaded into every channel at reset.
REQ-005 SHALL provide these ports, one per line (name  direction  width  meaning):
  clk  in  1  clock; reset, synchronous, active-high; clock clk
  reset  in  1  synchronous active-high reset
  en  in  NCH  per-channel run enable
  div_int  in  NCH*CNT_W  per-channel integer divisor; channel i occupies slice [i*CNT_W +: CNT_W]
  div_frac  in  NCH*FRAC_W  per-channel fractional divisor, same slicing scheme
  mode  in  NCH  0 = toggle clock output, 1 = tick-only
  load  in  NCH  request to capture div_int/div_frac/mode for the channel
  load_ack  out  NCH  1-cycle pulse when the captured settings become active
  clk_out  out  NCH  divided clock
  tick  out  NCH  1-cycle strobe per half-period event

Function (per channel i, channels fully independent)
REQ-006 Active settings SHALL be registered: act_int, act_frac, act_mode.
REQ-007 Counter SHALL use CNT_W+1 bits. Limit SHALL equal act_int + carry, where carry is the fractional-accumulator carry from the previous event. act_int = 2^CNT_W-1 with carry=1 SHALL NOT overflow.
REQ-008 While en=1, the counter SHALL increment each cycle until it equals the limit. At that edge (an "event") it SHALL do all of the following:
  reset the counter to 0;
  set acc <= acc + act_frac modulo 2^FRAC_W;
  latch the carry out of that addition for the next limit.
REQ-009 At each event, tick SHALL be 1 for exactly the following cycle; at all other times tick SHALL be 0.
REQ-010 In mode 0, clk_out SHALL toggle at each event. Average output period SHALL be 2*(act_int+1+act_frac/2^FRAC_W) clk cycles.
REQ-011 In mode 1, clk_out SHALL be held 1.
REQ-012 With act_int=0 and act_frac=0, an event SHALL occur every cycle: tick stays high continuously and clk_out toggles at clk/2.
REQ-013 When load=1, the channel SHALL capture its div_int/div_frac/mode slices into shadow registers and set a pending flag.
REQ-014 A load while pending is already set SHALL overwrite the shadow registers; only one load_ack SHALL be issued.
REQ-015 When pending is set and an event occurs, the shadow SHALL be copied to act_*. The same edge SHALL clear pending, clear acc and carry, and pulse load_ack in the next cycle. The period in progress SHALL complete with the old settings; no runt or glitch half-period is allowed.
REQ-016 If en=0, a pending load SHALL be applied on the next edge with the same act_*, pending, acc, carry and load_ack effects as REQ-015.
REQ-017 load and event on the same edge: the event SHALL apply the previously pending shadow, if any. The new capture SHALL become pending and be applied at the next event.
REQ-018 While en=0, the channel SHALL hold counter=0, acc=0, carry=0, tick=0, clk_out=1. Active and shadow settings SHALL be retained.
REQ-019 On the en 0->1 edge, counting SHALL start from 0. The first event SHALL occur act_int+1 cycles after en is sampled high.
REQ-020 Deasserting en mid-period SHALL abandon the period immediately and apply REQ-018 on the next edge.

Reset
REQ-021 When reset=1 at a clk edge, every channel SHALL set:
  counter=0, acc=0, carry=0, pending=0;
  tick=0, load_ack=0, clk_out=1;
  act_int=DEF_INT, act_frac=0, act_mode=0.
REQ-022 Reset SHALL take priority over en, load and events, including mid-period and mid-pending.

Structure
REQ-023 Package clk_div_pkg SHALL hold the mode constants (MODE_TOGGLE=0, MODE_TICK=1) and the default parameter values.
REQ-024 Per-channel logic SHALL live in sub-module clk_div_chan. The top SHALL generate NCH instances and do slicing only.

Verification
REQ-025 NCH=2, ch0 int=3 frac=0 mode 0: clk_out period = 8 cycles at 50% duty; tick every 4 cycles; ch1 at en=0 remains clk_out=1, tick=0.
REQ-026 int=2 frac=128 (FRAC_W=8): half-periods alternate 3,4,3,4 cycles; 256 events span exactly 896 cycles.
REQ-027 Running int=9, pulse load with int=1 mid-period: old half-period completes in 10 cycles; load_ack pulses once; subsequent half-periods are 2 cycles.
REQ-028 Two loads 2 cycles apart before the next event: only the second value takes effect; exactly one load_ack.
REQ-029 int=0 frac=0: tick stays 1 continuously and clk_out toggles every cycle. mode=1: clk_out stays 1 and tick is unchanged.
REQ-030 Assert reset during a pending load at counter=5: all outputs return to their reset values (REQ-021) next cycle; no load_ack ever pulses for the cancelled load.
